// File: rtl/if_prefetch_queue.sv
// Fetch stage: PC generator feeding a DEPTH-entry {pc, instr} FIFO; 1-cycle fetch-to-output, redirect flushes and restarts.
// Full queue still enqueues when the head is taken (no bubble); IF_PREFETCH_PERF_EN adds saturating perf counters.
module if_prefetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         redirect,
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [INSTR_W-1:0]           rom_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]           out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [15:0]                  perf_fetched,
    output logic [15:0]                  perf_flushed,
    output logic [15:0]                  perf_stall
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]  mem_pc_q    [DEPTH];
    logic [INSTR_W-1:0] mem_instr_q [DEPTH];
    logic               enq, deq;

    assign out_valid = (count_q != '0) & ~redirect;
    assign deq       = out_valid & out_ready;
    // A full queue may still accept when the head leaves in the same cycle.
    assign enq       = ~redirect & ((count_q != FULL_CNT) | deq);

    assign rom_addr  = fetch_pc_q;
    assign out_pc    = mem_pc_q[rd_ptr_q];
    assign out_instr = mem_instr_q[rd_ptr_q];
    assign count     = count_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq) begin
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (enq && !deq) begin
                count_d = count_q + CNT_W'(1);
            end else if (deq && !enq) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage contents are don't-care after reset; occupancy alone qualifies them.
    always_ff @(posedge CLK) begin
        if (enq && !RST) begin
            mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
            mem_instr_q[wr_ptr_q] <= rom_data;
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_flushed_q, perf_stall_q;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (enq) begin
                perf_fetched_q <= sat_add(perf_fetched_q, 16'd1);
            end
            if (redirect) begin
                perf_flushed_q <= sat_add(perf_flushed_q, 16'(count_q));
            end
            if ((count_q == FULL_CNT) && !deq && !redirect) begin
                perf_stall_q <= sat_add(perf_stall_q, 16'd1);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
    assign perf_stall   = perf_stall_q;
`endif
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: per-cycle vector table plus a held-redirect sequence.
module tb_if_prefetch_queue;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;
`ifdef IF_PREFETCH_PERF_EN
    logic [15:0] perf_fetched, perf_flushed, perf_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    assign rom_data = 32'hA000_0000 | {24'h0, rom_addr};

    if_prefetch_queue dut (
        .CLK         (CLK),
        .RST         (RST),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .count       (count)
`ifdef IF_PREFETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_flushed (perf_flushed),
        .perf_stall   (perf_stall)
`endif
    );

    typedef struct {
        logic        rst;
        logic        redir;
        logic [7:0]  rpc;
        logic        rdy;
        logic        exp_vld;
        logic [7:0]  exp_pc;
        logic [2:0]  exp_cnt;
        logic [7:0]  exp_rom;
        logic        chk_perf;
        logic [15:0] p_fetch;
        logic [15:0] p_flush;
        logic [15:0] p_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic redir, input logic [7:0] rpc,
                                input logic rdy, input logic vld, input logic [7:0] pc,
                                input logic [2:0] cnt, input logic [7:0] rom);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
        v.exp_vld = vld; v.exp_pc = pc; v.exp_cnt = cnt; v.exp_rom = rom;
        v.chk_perf = 1'b0; v.p_fetch = '0; v.p_flush = '0; v.p_stall = '0;
        vecs.push_back(v);
    endfunction

    function automatic void perf_exp(input logic [15:0] f, input logic [15:0] fl, input logic [15:0] st);
        int last;
        last = vecs.size() - 1;
        vecs[last].chk_perf = 1'b1;
        vecs[last].p_fetch  = f;
        vecs[last].p_flush  = fl;
        vecs[last].p_stall  = st;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        bit seen;
        // Columns: rst redir rpc rdy | exp_vld exp_pc exp_cnt exp_rom (values seen before the edge)
        add(1, 0, 8'h00, 0,  0, 8'h00, 0, 8'h00);
        // Fill with ID stalled: four entries, then full
        add(0, 0, 8'h00, 0,  0, 8'h00, 0, 8'h00);
        add(0, 0, 8'h00, 0,  1, 8'h00, 1, 8'h04);
        add(0, 0, 8'h00, 0,  1, 8'h00, 2, 8'h08);
        add(0, 0, 8'h00, 0,  1, 8'h00, 3, 8'h0C);
        add(0, 0, 8'h00, 0,  1, 8'h00, 4, 8'h10);
        add(0, 0, 8'h00, 0,  1, 8'h00, 4, 8'h10);
        // Drain at full rate from full: no bubble, count stays 4
        for (int k = 0; k < 8; k++) begin
            add(0, 0, 8'h00, 1,  1, 8'(4*k), 4, 8'(8'h10 + 4*k));
            if (k == 0) perf_exp(16'd4, 16'd0, 16'd2);
        end
        add(1, 0, 8'h00, 0,  1, 8'h20, 4, 8'h30);
        // Redirect to 0x08, fill to three, then redirect to 0x40
        add(0, 1, 8'h08, 0,  0, 8'h00, 0, 8'h00);
        add(0, 0, 8'h00, 0,  0, 8'h00, 0, 8'h08);
        add(0, 0, 8'h00, 0,  1, 8'h08, 1, 8'h0C);
        add(0, 0, 8'h00, 0,  1, 8'h08, 2, 8'h10);
        add(0, 1, 8'h40, 1,  0, 8'h00, 3, 8'h14);
        add(0, 0, 8'h00, 0,  0, 8'h00, 0, 8'h40);
        add(0, 0, 8'h00, 0,  1, 8'h40, 1, 8'h44);
        perf_exp(16'd4, 16'd3, 16'd0);
        // PC wrap past 0xFF with continuous draining
        add(0, 1, 8'hFC, 1,  0, 8'h00, 2, 8'h48);
        add(0, 0, 8'h00, 1,  0, 8'h00, 0, 8'hFC);
        add(0, 0, 8'h00, 1,  1, 8'hFC, 1, 8'h00);
        add(0, 0, 8'h00, 1,  1, 8'h00, 1, 8'h04);
        add(0, 0, 8'h00, 1,  1, 8'h04, 1, 8'h08);
        // Reset and redirect on the same edge: reset wins
        add(0, 0, 8'h00, 0,  1, 8'h08, 1, 8'h0C);
        add(1, 1, 8'h80, 0,  0, 8'h00, 2, 8'h10);
        add(0, 0, 8'h00, 0,  0, 8'h00, 0, 8'h00);
        add(0, 0, 8'h00, 0,  1, 8'h00, 1, 8'h04);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            RST         = vecs[i].rst;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            out_ready   = vecs[i].rdy;
            #1;
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_vld));
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].exp_cnt));
            chk($sformatf("v%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_rom));
            if (vecs[i].exp_vld) begin
                chk($sformatf("v%0d out_pc", i), 32'(out_pc), 32'(vecs[i].exp_pc));
                chk($sformatf("v%0d out_instr", i), out_instr, 32'hA000_0000 | 32'(vecs[i].exp_pc));
            end
`ifdef IF_PREFETCH_PERF_EN
            if (vecs[i].chk_perf) begin
                chk($sformatf("v%0d perf_fetched", i), 32'(perf_fetched), 32'(vecs[i].p_fetch));
                chk($sformatf("v%0d perf_flushed", i), 32'(perf_flushed), 32'(vecs[i].p_flush));
                chk($sformatf("v%0d perf_stall", i), 32'(perf_stall), 32'(vecs[i].p_stall));
            end
`endif
        end

        // Redirect held two cycles with a changing target: each cycle reflushes and reloads
        @(negedge CLK);
        RST = 1'b0; out_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h20;
        #1 chk("hold0 out_valid", 32'(out_valid), 32'd0);
        @(negedge CLK);
        chk("hold1 count", 32'(count), 32'd0);
        chk("hold1 rom_addr", 32'(rom_addr), 32'h20);
        redirect_pc = 8'h60;
        #1 chk("hold1 out_valid", 32'(out_valid), 32'd0);
        @(negedge CLK);
        chk("hold2 count", 32'(count), 32'd0);
        chk("hold2 rom_addr", 32'(rom_addr), 32'h60);
        redirect = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge CLK);
            if (out_valid) seen = 1'b1;
        end
        chk("hold out_valid timeout", 32'(seen), 32'd1);
        chk("hold out_pc", 32'(out_pc), 32'h60);
        chk("hold count", 32'(count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
